// File: rtl/coin_acceptor_if.sv
// Coin sensor inputs and coin-code outputs of the coin acceptor, bundled as one port.
// Latency: none; this is wiring only.
// Backpressure: none; the sensors cannot be stalled and the outputs are pulses or levels.
interface coin_acceptor_if;
  logic       coin5_raw;
  logic       coin10_raw;
  logic [1:0] coin_code;
  logic       reject;
  logic       overflow;
  logic [1:0] pending;

  // Sensor side: drives the raw slot sensors and observes the acceptor's outputs.
  modport master (
    output coin5_raw,
    output coin10_raw,
    input  coin_code,
    input  reject,
    input  overflow,
    input  pending
  );

  // Acceptor side: samples the raw sensors and produces the coin codes.
  modport slave (
    input  coin5_raw,
    input  coin10_raw,
    output coin_code,
    output reject,
    output overflow,
    output pending
  );
endinterface

// File: rtl/coin_acceptor.sv
// Debounces two coin sensors, queues qualified coins and emits them as spaced one-cycle codes.
// Latency: a stable rise first sampled at edge 0 appears on coin_code after edge DEB_CYCLES+3.
// Backpressure: none upstream; a 2-entry queue absorbs bursts and drops (overflow pulse) when full.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int GAP        = 1
) (
  input  logic           clk,
  input  logic           R,
  coin_acceptor_if.slave bus
);

  localparam logic [3:0] DEB_LAST  = 4'(DEB_CYCLES - 1);
  localparam logic [3:0] DEB_FULL  = 4'(DEB_CYCLES);
  localparam logic [2:0] GAP_LOAD  = 3'(GAP);
  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_FIVE = 2'b01;
  localparam logic [1:0] CODE_TEN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } chan_state_t;

  // Bit 0 is the 5-unit slot, bit 1 the 10-unit slot, everywhere below.
  logic [1:0] raw;
  logic [1:0] meta_q;
  logic [1:0] sync_q;
  logic [1:0] qual;

  assign raw = {bus.coin10_raw, bus.coin5_raw};

  // Two-flop synchronizer per sensor; nothing else ever looks at the raw pins.
  always_ff @(posedge clk) begin
    if (R) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // One debounce FSM per slot. A coin qualifies once on entry to HELD; it must then
  // stay absent for DEB_CYCLES samples before the slot re-arms, so bounce while the
  // coin sits in the slot never produces a second code.
  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    chan_state_t state_q;
    chan_state_t state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        qual_q;
    logic        qual_d;
    logic        in_s;

    assign in_s = sync_q[ch];

    // Slot state, stable-sample counter and the registered one-cycle qualify pulse.
    always_ff @(posedge clk) begin
      if (R) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        qual_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        qual_q  <= qual_d;
      end
    end

    // Next-state: count consecutive equal samples, qualify on the last confirm sample.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qual_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (in_s) begin
            state_d = CONFIRM;
            cnt_d   = 4'd1;
          end
        end
        CONFIRM: begin
          if (!in_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = HELD;
            cnt_d   = DEB_FULL;
            qual_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        HELD: begin
          if (!in_s) begin
            state_d = RELEASE;
            cnt_d   = 4'd1;
          end
        end
        RELEASE: begin
          if (in_s) begin
            state_d = HELD;
            cnt_d   = DEB_FULL;
          end else if (cnt_q == DEB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign qual[ch] = qual_q;
  end

  // Qualify combination: exactly one slot pushes its code, both at once is a jam.
  logic       push;
  logic       jam;
  logic [1:0] push_code;

  assign push      = qual[0] ^ qual[1];
  assign jam       = qual[0] & qual[1];
  assign push_code = qual[0] ? CODE_FIVE : CODE_TEN;

  // Two-entry arrival-order queue plus the output spacing counter.
  logic [1:0] fifo_q [2];
  logic [1:0] fifo_d [2];
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       drop;
  logic       pop;
  logic [2:0] gap_q;
  logic [2:0] gap_d;
  logic [1:0] code_q;
  logic [1:0] code_d;
  logic       reject_q;
  logic       overflow_q;

  // The head leaves only when the spacing counter has run out.
  assign pop = (gap_q == 3'd0) && (count_q != 2'd0);

  // Queue update: pop first, then place the new code behind whatever remains, so a
  // push and pop on a full queue both succeed; a push into a still-full queue drops.
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    drop    = 1'b0;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      fifo_d[1] = CODE_NONE;
      count_d   = count_q - 2'd1;
    end
    if (push) begin
      case (count_d)
        2'd0: begin
          fifo_d[0] = push_code;
          count_d   = 2'd1;
        end
        2'd1: begin
          fifo_d[1] = push_code;
          count_d   = 2'd2;
        end
        default: drop = 1'b1;
      endcase
    end
  end

  // Output stage: a popped code shows for one cycle, then GAP cycles of 00 follow.
  always_comb begin
    code_d = CODE_NONE;
    gap_d  = gap_q;
    if (pop) begin
      code_d = fifo_q[0];
      gap_d  = GAP_LOAD;
    end else if (gap_q != 3'd0) begin
      gap_d = gap_q - 3'd1;
    end
  end

  // Queue, spacing and output registers; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (R) begin
      fifo_q[0]  <= CODE_NONE;
      fifo_q[1]  <= CODE_NONE;
      count_q    <= '0;
      gap_q      <= '0;
      code_q     <= CODE_NONE;
      reject_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      code_q     <= code_d;
      reject_q   <= jam;
      overflow_q <= drop;
    end
  end

  assign bus.coin_code = code_q;
  assign bus.reject    = reject_q;
  assign bus.overflow  = overflow_q;
  assign bus.pending   = count_q;

  // The vending machine treats 11 as undefined, so it must never appear.
  a_code_legal : assert property (@(posedge clk) disable iff (R) code_q != 2'b11);

  // Occupancy can never exceed the two physical entries.
  a_pending_range : assert property (@(posedge clk) disable iff (R) count_q <= 2'd2);

  // A jam never pushes, so it can never coincide with a dropped push.
  a_jam_excl : assert property (@(posedge clk) disable iff (R) !(reject_q && overflow_q));

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: table-driven cycle vectors plus multi-cycle sequences.
// Latency: expected values are per clock edge, sampled 1 time unit after the rising edge.
// Backpressure: a second instance with a long output gap exercises the full-queue cases.
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic R;

  always #5 clk = ~clk;

  coin_acceptor_if fbus ();
  coin_acceptor_if sbus ();

  coin_acceptor #(.DEB_CYCLES(4), .GAP(1)) u_fast (.clk(clk), .R(R), .bus(fbus));
  coin_acceptor #(.DEB_CYCLES(4), .GAP(7)) u_slow (.clk(clk), .R(R), .bus(sbus));

  typedef struct {
    bit         r;
    bit         c5;
    bit         c10;
    logic [1:0] code;
    bit         rej;
    bit         ovf;
    logic [1:0] pend;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [1:0] code_log [128];
  logic [1:0] pend_log [128];
  logic       ovf_log  [128];
  logic       rej_log  [128];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input bit r, input bit c5, input bit c10, input logic [1:0] code,
                              input bit rej, input bit ovf, input logic [1:0] pend);
    vec_t v;
    v.r = r; v.c5 = c5; v.c10 = c10; v.code = code; v.rej = rej; v.ovf = ovf; v.pend = pend;
    vecs.push_back(v);
  endfunction

  function automatic logic [127:0] ones(input int lo, input int hi);
    logic [127:0] v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Drive per-edge reset/sensor patterns into one instance and log its outputs after each edge.
  task automatic run_pat(input bit slow, input logic [127:0] rp, input logic [127:0] c5p,
                         input logic [127:0] c10p, input int n);
    for (int k = 0; k < n; k++) begin
      R               = rp[k];
      fbus.coin5_raw  = slow ? 1'b0 : c5p[k];
      fbus.coin10_raw = slow ? 1'b0 : c10p[k];
      sbus.coin5_raw  = slow ? c5p[k] : 1'b0;
      sbus.coin10_raw = slow ? c10p[k] : 1'b0;
      @(posedge clk);
      #1;
      code_log[k] = slow ? sbus.coin_code : fbus.coin_code;
      pend_log[k] = slow ? sbus.pending   : fbus.pending;
      ovf_log[k]  = slow ? sbus.overflow  : fbus.overflow;
      rej_log[k]  = slow ? sbus.reject    : fbus.reject;
    end
  endtask

  // Compare the emitted code stream (first code in bits 1:0) and its spacing.
  task automatic check_codes(input string nm, input int n, input int exp_n, input logic [7:0] exp_codes);
    int         got_n   = 0;
    logic [7:0] got     = '0;
    int         adj     = 0;
    int         illegal = 0;
    for (int k = 0; k < n; k++) begin
      if (code_log[k] == 2'b11) illegal++;
      if (code_log[k] != 2'b00) begin
        if (got_n < 4) got[2*got_n +: 2] = code_log[k];
        got_n++;
        if (k > 0 && code_log[k-1] != 2'b00) adj++;
      end
    end
    check({nm, "_count"}, got_n, exp_n);
    check({nm, "_order"}, got, exp_codes);
    check({nm, "_spacing"}, adj, 0);
    check({nm, "_illegal"}, illegal, 0);
  endtask

  function automatic int count_ones(input int n, input bit use_ovf);
    int c = 0;
    for (int k = 0; k < n; k++) c += use_ovf ? int'(ovf_log[k]) : int'(rej_log[k]);
    return c;
  endfunction

  initial begin
    R               = 1'b1;
    fbus.coin5_raw  = 1'b0;
    fbus.coin10_raw = 1'b0;
    sbus.coin5_raw  = 1'b0;
    sbus.coin10_raw = 1'b0;

    // Single 5-unit coin held 10 samples: code 01 only after edge 7.
    add(1, 0, 0, 2'b00, 0, 0, 2'd0);
    add(1, 0, 0, 2'b00, 0, 0, 2'd0);
    for (int k = 0; k < 6; k++) add(0, 1, 0, 2'b00, 0, 0, 2'd0);
    add(0, 1, 0, 2'b00, 0, 0, 2'd1);
    add(0, 1, 0, 2'b01, 0, 0, 2'd0);
    for (int k = 8; k < 10; k++) add(0, 1, 0, 2'b00, 0, 0, 2'd0);
    for (int k = 10; k < 18; k++) add(0, 0, 0, 2'b00, 0, 0, 2'd0);
    // Three-sample glitch on the 10-unit slot: nothing queued, nothing emitted.
    add(1, 0, 0, 2'b00, 0, 0, 2'd0);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 2'b00, 0, 0, 2'd0);
    for (int k = 3; k < 10; k++) add(0, 0, 0, 2'b00, 0, 0, 2'd0);
    // Both slots rise together: a single reject pulse after edge 6, no code.
    add(1, 0, 0, 2'b00, 0, 0, 2'd0);
    for (int k = 0; k < 10; k++) add(0, 1, 1, 2'b00, (k == 6), 0, 2'd0);
    for (int k = 10; k < 18; k++) add(0, 0, 0, 2'b00, 0, 0, 2'd0);
    // Coin already present across reset release counts from the first free sample.
    add(1, 1, 0, 2'b00, 0, 0, 2'd0);
    add(1, 1, 0, 2'b00, 0, 0, 2'd0);
    for (int k = 0; k < 6; k++) add(0, 1, 0, 2'b00, 0, 0, 2'd0);
    add(0, 1, 0, 2'b00, 0, 0, 2'd1);
    add(0, 1, 0, 2'b01, 0, 0, 2'd0);
    add(0, 1, 0, 2'b00, 0, 0, 2'd0);
    for (int k = 9; k < 17; k++) add(0, 0, 0, 2'b00, 0, 0, 2'd0);
    // Reset in the middle of confirmation discards the partial coin.
    for (int k = 0; k < 4; k++) add(0, 1, 0, 2'b00, 0, 0, 2'd0);
    add(1, 1, 0, 2'b00, 0, 0, 2'd0);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 2'b00, 0, 0, 2'd0);

    foreach (vecs[i]) begin
      R               = vecs[i].r;
      fbus.coin5_raw  = vecs[i].c5;
      fbus.coin10_raw = vecs[i].c10;
      @(posedge clk);
      #1;
      check($sformatf("vec[%0d]", i),
            {fbus.coin_code, fbus.reject, fbus.overflow, fbus.pending},
            {vecs[i].code, vecs[i].rej, vecs[i].ovf, vecs[i].pend});
    end

    // Alternating 5, 10, 5 with the output busy: codes in order, each followed by a gap.
    run_pat(0, ones(0, 2), '0, '0, 4);
    run_pat(0, '0, ones(0, 3) | ones(8, 11), ones(1, 4), 30);
    check_codes("alt_fast", 30, 3, 8'h19);
    check("alt_fast_first", code_log[7], 2'b01);
    check("alt_fast_second", code_log[9], 2'b10);
    check("alt_fast_third", code_log[15], 2'b01);
    check("alt_fast_ovf", count_ones(30, 1), 0);

    // Long output gap: queue fills, full push+pop keeps 2, a fifth coin is dropped.
    run_pat(1, ones(0, 2), '0, '0, 4);
    run_pat(1, '0, ones(0, 3) | ones(8, 11) | ones(16, 19), ones(1, 4) | ones(9, 12), 45);
    check("full_pend_e14", pend_log[14], 2'd2);
    check("full_pushpop_pend", pend_log[15], 2'd2);
    check("full_pushpop_code", code_log[15], 2'b10);
    check("full_drop_ovf", ovf_log[22], 1'b1);
    check("full_drop_pend", pend_log[22], 2'd2);
    check("full_ovf_count", count_ones(45, 1), 1);
    check_codes("full_slow", 45, 4, 8'h99);

    // One-cycle reset while two codes wait: both are discarded.
    run_pat(1, ones(0, 2), '0, '0, 4);
    run_pat(1, ones(15, 15), ones(0, 3) | ones(8, 11), ones(1, 4), 40);
    check("rst_q_pend_before", pend_log[14], 2'd2);
    check("rst_q_pend_after", pend_log[15], 2'd0);
    check("rst_q_code_after", code_log[15], 2'b00);
    begin
      int late = 0;
      for (int k = 15; k < 40; k++) if (pend_log[k] != 2'd0 || code_log[k] != 2'b00) late++;
      check("rst_q_quiet", late, 0);
    end
    check_codes("rst_q", 40, 1, 8'h01);

    // Long hold followed by bounce on removal: still a single code.
    run_pat(0, ones(0, 2), '0, '0, 4);
    run_pat(0, '0, ones(0, 49) | ones(52, 53) | ones(56, 57), '0, 80);
    check_codes("bounce", 80, 1, 8'h01);
    check("bounce_rej", count_ones(80, 0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, number of consecutive stable samples that qualify a coin or re-arm a channel; legal range 2..15.
REQ-002 SHALL have parameter GAP, default 1, number of idle (2'b00) cycles forced on coin_code after each emitted code; legal range 1..7.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port R, input, 1 bit, reset; reset is synchronous and active-high.
REQ-005 SHALL have port coin5_raw, input, 1 bit, asynchronous sensor for the 5-unit coin slot; high = coin present.
REQ-006 SHALL have port coin10_raw, input, 1 bit, asynchronous sensor for the 10-unit coin slot; high = coin present.
REQ-007 SHALL have port coin_code, output, 2 bits, the coin code that feeds the vending machine's 2-bit coin input: 00 none, 01 five, 10 ten; 11 never driven.
REQ-008 SHALL have port reject, output, 1 bit, one-cycle pulse when a coin is rejected as a jam.
REQ-009 SHALL have port overflow, output, 1 bit, one-cycle pulse when a qualified coin is dropped because the queue is full.
REQ-010 SHALL have port pending, output, 2 bits, number of queued codes not yet emitted (0..2).

Function
REQ-011 SHALL pass each raw input through its own 2-flop synchronizer before any other logic.
REQ-012 SHALL run one FSM per channel with states IDLE, CONFIRM, HELD, RELEASE.
REQ-013 IDLE->CONFIRM when the synchronized input is 1; the per-channel counter loads 1.
REQ-014 CONFIRM: counter increments while the input stays 1; input 0 -> IDLE with no output; counter reaching DEB_CYCLES -> HELD and asserts that channel's qualify for exactly that one cycle.
REQ-015 HELD: stays while the input is 1; input 0 -> RELEASE with counter = 1.
REQ-016 RELEASE: counter increments while the input is 0; input 1 -> HELD; counter reaching DEB_CYCLES -> IDLE; a held coin never qualifies twice.
REQ-017 Both channels qualifying in the same cycle SHALL push nothing and pulse reject in the next cycle.
REQ-018 A single qualify SHALL push its code (01 or 10) into a 2-entry FIFO at the next edge.
REQ-019 A push with the FIFO full and no pop at the same edge SHALL drop the code, pulse overflow for one cycle, and leave the FIFO unchanged.
REQ-020 A push and a pop at the same edge with the FIFO full SHALL both succeed; pending stays 2.
REQ-021 Output stage: when the gap counter is 0 and the FIFO is non-empty, it SHALL pop the head and drive the code on coin_code for exactly one cycle, then drive 00 for GAP cycles.
REQ-022 Codes SHALL be emitted in arrival order; coin_code SHALL be 00 in every cycle that is not an emit cycle.
REQ-023 With the FIFO empty and the output idle, a raw rise first sampled at edge 0 and held stable SHALL put the code on coin_code during the cycle after edge DEB_CYCLES+3.
REQ-024 pending SHALL equal FIFO occupancy after each edge, including during a same-edge push and pop.

Reset
REQ-025 While R=1 at a clock edge: synchronizers to 0, both FSMs to IDLE, counters 0, FIFO emptied, gap counter 0.
REQ-026 After any reset edge: coin_code=00, reject=0, overflow=0, pending=0.
REQ-027 R asserted mid-debounce or mid-gap SHALL discard all queued and partially qualified coins.
REQ-028 A coin held high across the release of R SHALL qualify normally, counting from the first post-reset sample.

Verification
REQ-029 Reset then coin5_raw high for 10 cycles (DEB_CYCLES=4, GAP=1): coin_code=01 for exactly one cycle, 7 edges after the first sample; no other nonzero codes.
REQ-030 coin10_raw 3-cycle high glitch, then low: coin_code stays 00, pending stays 0.
REQ-031 coin5_raw and coin10_raw rise on the same edge, both held 10 cycles: one reject pulse, coin_code stays 00.
REQ-032 Three alternating qualified coins (5, 10, 5) arriving while the output is busy: codes 01,10,01 each separated by at least GAP zeros, or overflow=1 on the third if the FIFO is full at its push.
REQ-033 R pulsed for one cycle while pending=2: pending=0 and coin_code=00 from the next cycle; no queued code is ever emitted.
REQ-034 Coin held high for 50 cycles, then bouncing low/high every 2 cycles for 10 cycles: exactly one code is emitted.
